// File: rtl/mem_stage.sv
// MIPS memory-access stage: data memory with byte/half/word loads and stores,
// misalignment detection, MEM/WB pipeline register and a registered debug read port.
module mem_stage #(
  parameter int NB_ADDR   = 32,
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int MEM_DEPTH = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_ADDR-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_data_store,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_ADDR-1:0] o_alu_result,
  output logic [NB_REG-1:0]  o_rd,
  output logic               o_reg_write,
  output logic               o_mem_to_reg,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_dbg_data
);

  localparam int AW      = $clog2(MEM_DEPTH);
  localparam int NB_LANE = NB_DATA / 8;

  logic [NB_DATA-1:0] mem [MEM_DEPTH];

  logic [AW-1:0]      word_idx;
  logic [AW-1:0]      dbg_idx;
  logic [1:0]         lane;
  logic               is_byte;
  logic               is_half;
  logic               is_word;
  logic               misaligned;
  logic               do_store;
  logic               do_load;
  logic [NB_LANE-1:0] lane_en;
  logic [NB_DATA-1:0] store_word;
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         load_byte;
  logic [15:0]        load_half;
  logic [NB_DATA-1:0] load_ext;
  logic               unused_dbg_hi;

  // Upper address bits are dropped, so accesses alias modulo the memory size.
  assign word_idx      = i_alu_result[AW+1:2];
  assign lane          = i_alu_result[1:0];
  assign dbg_idx       = i_dbg_addr[AW-1:0];
  assign unused_dbg_hi = ^i_dbg_addr[NB_ADDR-1:AW];

  assign is_byte = (i_size == 2'b00);
  assign is_half = (i_size == 2'b01);
  assign is_word = i_size[1];

  assign misaligned = (i_mem_read | i_mem_write) &
                      ((is_half & lane[0]) | (is_word & (lane != 2'b00)));

  assign do_store = i_enable & i_mem_write & ~misaligned & ~i_reset;
  assign do_load  = i_mem_read & ~i_mem_write & ~misaligned;

  // Lane strobes and store data replicated into each little-endian byte lane.
  generate
    for (genvar gi = 0; gi < NB_LANE; gi++) begin : g_lane
      localparam logic [1:0] LANE_ID = 2'(gi);
      assign lane_en[gi] = is_word |
                           (is_half & (lane[1] == LANE_ID[1])) |
                           (is_byte & (lane == LANE_ID));
      assign store_word[gi*8 +: 8] = is_word ? i_data_store[gi*8 +: 8] :
                                     is_half ? i_data_store[(gi%2)*8 +: 8] :
                                               i_data_store[7:0];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (do_store) begin
      for (int b = 0; b < NB_LANE; b++) begin
        if (lane_en[b]) mem[word_idx][b*8 +: 8] <= store_word[b*8 +: 8];
      end
    end
  end

  assign rd_word   = mem[word_idx];
  assign load_byte = rd_word[{lane, 3'b000} +: 8];
  assign load_half = lane[1] ? rd_word[16 +: 16] : rd_word[0 +: 16];

  always_comb begin
    load_ext = rd_word;
    if (is_byte) begin
      load_ext = {{(NB_DATA-8){~i_unsigned & load_byte[7]}}, load_byte};
    end else if (is_half) begin
      load_ext = {{(NB_DATA-16){~i_unsigned & load_half[15]}}, load_half};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (i_enable) begin
      o_read_data  <= do_load ? load_ext : '0;
      o_alu_result <= i_alu_result;
      o_rd         <= i_rd;
      o_reg_write  <= i_reg_write & ~misaligned;
      o_mem_to_reg <= i_mem_to_reg;
      o_misaligned <= misaligned;
    end
  end

  // Debug read ignores the pipeline enable; a same-edge store is not visible yet.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_dbg_data <= '0;
    end else begin
      o_dbg_data <= mem[dbg_idx];
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: loads/stores, extension, misalignment,
// enable hold, aliasing, debug port and asynchronous reset.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [31:0] i_alu_result;
  logic [31:0] i_data_store;
  logic [4:0]  i_rd;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_reg_write;
  logic        i_mem_to_reg;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_dbg_addr;
  logic [31:0] o_read_data;
  logic [31:0] o_alu_result;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic        o_mem_to_reg;
  logic        o_misaligned;
  logic [31:0] o_dbg_data;

  int vectors = 0;
  int miscompares = 0;

  mem_stage #(.NB_ADDR(32), .NB_DATA(32), .NB_REG(5), .MEM_DEPTH(256)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_alu_result(i_alu_result), .i_data_store(i_data_store), .i_rd(i_rd),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
    .i_mem_to_reg(i_mem_to_reg), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_dbg_addr(i_dbg_addr), .o_read_data(o_read_data), .o_alu_result(o_alu_result),
    .o_rd(o_rd), .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
    .o_misaligned(o_misaligned), .o_dbg_data(o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
    $display("t=%0t en=%0b rd=%0b wr=%0b sz=%0d addr=%h st=%h -> rdata=%h mis=%0b rw=%0b dbg=%h",
             $time, i_enable, i_mem_read, i_mem_write, i_size, i_alu_result, i_data_store,
             o_read_data, o_misaligned, o_reg_write, o_dbg_data);
  endtask

  task automatic set_idle();
    i_enable = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0; i_reg_write = 1'b0;
    i_mem_to_reg = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
    i_alu_result = '0; i_data_store = '0; i_rd = '0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data);
    i_enable = 1'b1; i_mem_read = rd; i_mem_write = wr; i_size = sz; i_unsigned = uns;
    i_alu_result = addr; i_data_store = data; i_reg_write = rd; i_mem_to_reg = rd;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_dbg_addr = '0;
    set_idle();
    repeat (2) @(posedge i_clk);
    #1;
    vectors++;
    if ({o_read_data, o_alu_result, o_rd, o_reg_write, o_mem_to_reg, o_misaligned, o_dbg_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdata=%h alu=%h rd=%0d rw=%0b m2r=%0b mis=%0b dbg=%h expected all 0",
               o_read_data, o_alu_result, o_rd, o_reg_write, o_mem_to_reg, o_misaligned, o_dbg_data);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_word();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF); tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0); tick();
    vectors++;
    if (o_read_data !== 32'hDEADBEEF || o_misaligned !== 1'b0 || o_reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL word_load: rdata=%h mis=%0b rw=%0b expected DEADBEEF 0 1", o_read_data, o_misaligned, o_reg_write);
    end
  endtask

  task automatic test_byte();
    logic [31:0] exp_b [4];
    exp_b[0] = 32'h00000001; exp_b[1] = 32'h0000007F; exp_b[2] = 32'hFFFFFFFF; exp_b[3] = 32'hFFFFFF80;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h20 + 32'(k), 32'h0); tick();
      vectors++;
      if (o_read_data !== exp_b[k]) begin
        miscompares++;
        $display("FAIL byte_load_signed[%0d]: got %h expected %h", k, o_read_data, exp_b[k]);
      end
    end
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0); tick();
    vectors++;
    if (o_read_data !== 32'h00000080) begin
      miscompares++;
      $display("FAIL byte_load_unsigned: got %h expected 00000080", o_read_data);
    end
  endtask

  task automatic test_half();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344); tick();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h5555ABCD); tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0); tick();
    vectors++;
    if (o_read_data !== 32'hABCD3344) begin
      miscompares++;
      $display("FAIL half_store_merge: got %h expected ABCD3344", o_read_data);
    end
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0); tick();
    vectors++;
    if (o_read_data !== 32'hFFFFABCD) begin
      miscompares++;
      $display("FAIL half_load_signed: got %h expected FFFFABCD", o_read_data);
    end
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h30, 32'h0); tick();
    vectors++;
    if (o_read_data !== 32'h00003344) begin
      miscompares++;
      $display("FAIL half_load_low_unsigned: got %h expected 00003344", o_read_data);
    end
  endtask

  task automatic test_misaligned();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADF00D); tick();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h41, 32'h12345678); i_reg_write = 1'b1; tick();
    vectors++;
    if (o_misaligned !== 1'b1 || o_reg_write !== 1'b0 || o_read_data !== 32'h0 || o_alu_result !== 32'h41) begin
      miscompares++;
      $display("FAIL misaligned_word_store: mis=%0b rw=%0b rdata=%h alu=%h expected 1 0 0 41",
               o_misaligned, o_reg_write, o_read_data, o_alu_result);
    end
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h43, 32'h0); tick();
    vectors++;
    if (o_misaligned !== 1'b1 || o_reg_write !== 1'b0 || o_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL misaligned_half_load: mis=%0b rw=%0b rdata=%h expected 1 0 0", o_misaligned, o_reg_write, o_read_data);
    end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0); tick();
    vectors++;
    if (o_read_data !== 32'h0BADF00D || o_misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned_no_write: got %h mis=%0b expected 0BADF00D 0", o_read_data, o_misaligned);
    end
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0); tick();
    vectors++;
    if (o_read_data !== 32'hFFFFFFF0 || o_misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_odd_aligned: got %h mis=%0b expected FFFFFFF0 0", o_read_data, o_misaligned);
    end
  endtask

  task automatic test_enable();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h0000AAAA); tick();
    set_idle(); i_dbg_addr = 32'h14; tick(); tick();
    vectors++;
    if (o_dbg_data !== 32'h0000AAAA) begin
      miscompares++;
      $display("FAIL dbg_read: got %h expected 0000AAAA", o_dbg_data);
    end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h52, 32'h0); i_rd = 5'd3; tick();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h5); i_rd = 5'd9; i_enable = 1'b0; tick(); tick();
    vectors++;
    if (o_dbg_data !== 32'h0000AAAA || o_misaligned !== 1'b1 || o_rd !== 5'd3 || o_alu_result !== 32'h52) begin
      miscompares++;
      $display("FAIL enable_hold: dbg=%h mis=%0b rd=%0d alu=%h expected 0000AAAA 1 3 52",
               o_dbg_data, o_misaligned, o_rd, o_alu_result);
    end
  endtask

  task automatic test_alias();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE0001); tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0); i_dbg_addr = 32'h100; tick();
    vectors++;
    if (o_read_data !== 32'hCAFE0001 || o_dbg_data !== 32'hCAFE0001) begin
      miscompares++;
      $display("FAIL alias_word0: rdata=%h dbg=%h expected CAFE0001 CAFE0001", o_read_data, o_dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    i_dbg_addr = 32'h18;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h60, 32'h111); tick();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h60, 32'h222); tick();
    vectors++;
    if (o_dbg_data !== 32'h111) begin
      miscompares++;
      $display("FAIL dbg_same_edge_old: got %h expected 00000111", o_dbg_data);
    end
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h70, 32'h3C); tick();
    vectors++;
    if (o_read_data !== 32'h0 || o_dbg_data !== 32'h222) begin
      miscompares++;
      $display("FAIL read_write_both: rdata=%h dbg=%h expected 0 222", o_read_data, o_dbg_data);
    end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h70, 32'h0); tick();
    vectors++;
    if (o_read_data !== 32'h3C) begin
      miscompares++;
      $display("FAIL raw_after_both: got %h expected 0000003C", o_read_data);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0); i_rd = 5'd5; tick();
    vectors++;
    if (o_read_data !== 32'h222 || o_rd !== 5'd5) begin
      miscompares++;
      $display("FAIL pre_reset_load: rdata=%h rd=%0d expected 222 5", o_read_data, o_rd);
    end
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h60, 32'h999);
    #2; i_reset = 1'b1; #1;
    vectors++;
    if (o_read_data !== 32'h0 || o_rd !== 5'd0 || o_alu_result !== 32'h0 || o_dbg_data !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset_clear: rdata=%h rd=%0d alu=%h dbg=%h expected all 0",
               o_read_data, o_rd, o_alu_result, o_dbg_data);
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_enable = 1'b0; tick();
    vectors++;
    if (o_alu_result !== 32'h0 || o_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release_hold: alu=%h rdata=%h expected 0 0", o_alu_result, o_read_data);
    end
    set_idle(); i_dbg_addr = 32'h18; tick(); tick();
    vectors++;
    if (o_dbg_data !== 32'h222) begin
      miscompares++;
      $display("FAIL reset_suppress_write: got %h expected 00000222", o_dbg_data);
    end
  endtask

  task automatic test_passthrough();
    set_idle(); i_alu_result = 32'h1234; i_rd = 5'd7; i_reg_write = 1'b1; tick();
    vectors++;
    if (o_alu_result !== 32'h1234 || o_rd !== 5'd7 || o_reg_write !== 1'b1 ||
        o_read_data !== 32'h0 || o_mem_to_reg !== 1'b0 || o_misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL passthrough: alu=%h rd=%0d rw=%0b rdata=%h m2r=%0b mis=%0b expected 1234 7 1 0 0 0",
               o_alu_result, o_rd, o_reg_write, o_read_data, o_mem_to_reg, o_misaligned);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_enable();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    test_passthrough();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
